// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response buffering, and redirect handling that discards stale responses.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_curr_out,
  output logic [31:0] pc_plus4_out
);

  localparam int          IW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW  = $clog2(FIFO_DEPTH + 1);
  localparam int          SW  = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_cnt_q, discard_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [IW-1:0] fifo_head_q, fifo_head_d, fifo_tail_q, fifo_tail_d;
  logic [IW-1:0] infl_head_q, infl_head_d, infl_tail_q, infl_tail_d;
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
  logic [31:0]   infl_pc_q   [FIFO_DEPTH];
  logic [31:0]   infl_pc_d   [FIFO_DEPTH];

  logic [SW-1:0] occupancy;
  logic          req_hs, resp_ok, resp_keep, pop;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request channel: a transfer happens on a cycle where valid && ready; while
  // valid && !ready the address is held because fetch_pc only moves on transfer.
  always_comb begin
    occupancy      = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    imem_req_valid = !rst && !redirect_valid && (occupancy < SW'(FIFO_DEPTH));
    imem_req_addr  = fetch_pc_q;
    instr_valid    = (fifo_cnt_q != '0);
    req_hs         = imem_req_valid && imem_req_ready;
    resp_ok        = imem_resp_valid && (outstanding_q != '0);
    resp_keep      = resp_ok && (discard_cnt_q == '0) && !redirect_valid;
    pop            = instr_valid && !stall && !redirect_valid;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(resp_ok);
    discard_cnt_d = discard_cnt_q;
    infl_pc_d     = infl_pc_q;
    infl_head_d   = infl_head_q;
    infl_tail_d   = infl_tail_q;
    fifo_data_d   = fifo_data_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_head_d   = fifo_head_q;
    fifo_tail_d   = fifo_tail_q;
    fifo_cnt_d    = fifo_cnt_q;
    last_pc_d     = pc_curr_out;

    if (req_hs) begin
      infl_pc_d[infl_tail_q] = fetch_pc_q;
      infl_tail_d            = next_ptr(infl_tail_q);
      fetch_pc_d             = fetch_pc_q + 32'd4;
    end
    if (resp_ok) begin
      infl_head_d = next_ptr(infl_head_q);
    end

    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old path.
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      discard_cnt_d = outstanding_q - CW'(resp_ok);
      fifo_cnt_d    = '0;
      fifo_head_d   = '0;
      fifo_tail_d   = '0;
    end else begin
      if (resp_ok && (discard_cnt_q != '0)) begin
        discard_cnt_d = discard_cnt_q - 1'b1;
      end
      if (resp_keep) begin
        fifo_data_d[fifo_tail_q] = imem_resp_data;
        fifo_pc_d[fifo_tail_q]   = infl_pc_q[infl_head_q];
        fifo_tail_d              = next_ptr(fifo_tail_q);
      end
      if (pop) begin
        fifo_head_d = next_ptr(fifo_head_q);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(resp_keep) - CW'(pop);
    end
  end

  always_comb begin
    instruction_out = instr_valid ? fifo_data_q[fifo_head_q] : NOP;
    pc_curr_out     = instr_valid ? fifo_pc_q[fifo_head_q] : last_pc_q;
    pc_plus4_out    = pc_curr_out + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      last_pc_q     <= '0;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      fifo_cnt_q    <= '0;
      fifo_head_q   <= '0;
      fifo_tail_q   <= '0;
      infl_head_q   <= '0;
      infl_tail_q   <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_head_q   <= fifo_head_d;
      fifo_tail_q   <= fifo_tail_d;
      infl_head_q   <= infl_head_d;
      infl_tail_q   <= infl_tail_d;
    end
  end

  // Storage is only read under valid pointers/counts, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_pc_q   <= fifo_pc_d;
    infl_pc_q   <= infl_pc_d;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model plus an expected-PC
// scoreboard fed on each request handshake and consumed on each output pop.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instruction_out;
  logic [31:0] pc_curr_out;
  logic [31:0] pc_plus4_out;

  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] model_pc = RST_PC;
  logic        mem_hold = 1'b0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          pop_cnt = 0;

  if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .instr_valid(instr_valid),
    .instruction_out(instruction_out), .pc_curr_out(pc_curr_out),
    .pc_plus4_out(pc_plus4_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: observe at negedge, then update the memory model just after posedge.
  task automatic step();
    logic        hs;
    logic [31:0] ha;
    logic [31:0] e;
    @(negedge clk);
    hs = imem_req_valid && imem_req_ready;
    ha = imem_req_addr;
    if (instr_valid && !stall && !redirect_valid && !rst) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", instr_valid, 32'h0);
      end else begin
        e = exp_q.pop_front();
        pop_cnt++;
        check("out_pc", pc_curr_out, e);
        check("out_instr", instruction_out, mem_word(e));
        check("out_pc4", pc_plus4_out, e + 32'd4);
      end
    end
    if (redirect_valid) begin
      check("req_in_redirect", imem_req_valid, 32'h0);
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end
    if (rst) begin
      exp_q.delete();
      model_pc = RST_PC;
    end
    if (hs) begin
      check("req_addr", ha, model_pc);
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    if (hs) mem_q.push_back(ha);
    if (!mem_hold && mem_q.size() != 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 32'h0);
    check({tag, "_req_addr"}, imem_req_addr, RST_PC);
    check({tag, "_instr_valid"}, instr_valid, 32'h0);
    check({tag, "_instr"}, instruction_out, 32'h0000_0013);
    check({tag, "_pc"}, pc_curr_out, 32'h0);
    check({tag, "_pc4"}, pc_plus4_out, 32'h4);
  endtask

  initial begin
    int p0;
    int n;
    // Reset values and first-fetch latency
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    step();
    check("lat_cycle1_valid", instr_valid, 32'h0);
    step();
    check("lat_cycle2_valid", instr_valid, 32'h1);
    check("lat_first_pc", pc_curr_out, RST_PC);
    repeat (12) step();

    // Stall freezes outputs; credit runs out and requests stop
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", instr_valid, 32'h1);
      check("stall_pc", pc_curr_out, (exp_q.size() != 0) ? exp_q[0] : 32'hxxxx_xxxx);
    end
    check("stall_credit_exhausted", imem_req_valid, 32'h0);
    stall = 1'b0;
    repeat (10) step();

    // Ready low: address held, fetch_pc not advanced; pipeline drains
    imem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 3) check("ready_low_addr", imem_req_addr, model_pc);
    end
    check("drained_empty", instr_valid, 32'h0);

    // Two requests in flight, then redirect to a misaligned target
    mem_hold = 1'b1;
    imem_req_ready = 1'b1;
    step();
    step();
    check("two_inflight_no_credit", imem_req_valid, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2002;
    step();
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    check("redir_fifo_empty", instr_valid, 32'h0);
    check("redir_next_addr", imem_req_addr, 32'h0000_2000);
    p0 = pop_cnt;
    repeat (12) step();
    check("redir_progress", (pop_cnt > p0), 32'h1);

    // Redirect coincident with a response while stalled
    n = 0;
    while (!(imem_resp_valid && instr_valid) && n < 20) begin
      step();
      n++;
    end
    check("coinc_setup_found", (n < 20), 32'h1);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    check("coinc_fifo_cleared", instr_valid, 32'h0);
    stall = 1'b0;
    p0 = pop_cnt;
    repeat (12) step();
    check("coinc_progress", (pop_cnt > p0), 32'h1);

    // Address wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    repeat (14) step();
    check("wrap_passed_zero", (model_pc < 32'h0000_0100), 32'h1);

    // Reset mid-stream, then late responses after release are ignored
    mem_hold = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    mem_hold = 1'b0;
    repeat (3) step();
    check("late_resp_ignored_valid", instr_valid, 32'h0);
    check("late_resp_ignored_pc", pc_curr_out, 32'h0);
    mem_q.delete();
    imem_req_ready = 1'b1;
    p0 = pop_cnt;
    repeat (10) step();
    check("post_reset_progress", (pop_cnt > p0), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
